// File: rtl/wb_sram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a single-port SRAM wrapper.
// Every transaction is followed by a one-cycle idle gap before the next arbitration.
module wb_sram_arbiter #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_sel_i,
  input  logic [31:0]   m0_dat_i,
  output logic [31:0]   m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_sel_i,
  input  logic [31:0]   m1_dat_i,
  output logic [31:0]   m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic [AW-1:0] s_adr_o,
  output logic          s_we_o,
  output logic [3:0]    s_sel_o,
  output logic [31:0]   s_dat_o,
  input  logic [31:0]   s_dat_i,
  input  logic          s_ack_i,
  output logic [1:0]    gnt_o
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t          r_state;
  logic [1:0]      r_gnt;
  logic            r_last;
  logic [CW-1:0]   r_cnt;

  logic w_req0;
  logic w_req1;
  logic w_req_g;
  logic w_in_grant;
  logic w_sel1;
  logic w_last_cyc;
  logic w_timeout;

  assign w_req0     = m0_cyc_i & m0_stb_i;
  assign w_req1     = m1_cyc_i & m1_stb_i;
  assign w_in_grant = (r_state == GRANT);
  assign w_sel1     = r_gnt[1];
  assign w_req_g    = w_sel1 ? w_req1 : w_req0;
  assign w_last_cyc = (r_cnt == CW'(TIMEOUT - 1));
  // Ack wins over abort, abort wins over timeout.
  assign w_timeout  = w_in_grant & ~s_ack_i & w_req_g & w_last_cyc;

  // r_last remembers the most recent owner (1 = M1) for round-robin tie breaks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_gnt   <= 2'b00;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req0 | w_req1) begin
            r_state <= GRANT;
            r_cnt   <= '0;
            if (w_req0 & w_req1)
              r_gnt <= r_last ? 2'b01 : 2'b10;
            else
              r_gnt <= w_req1 ? 2'b10 : 2'b01;
          end
        end
        GRANT: begin
          if (s_ack_i | ~w_req_g | w_last_cyc) begin
            r_state <= GAP;
            r_gnt   <= 2'b00;
            r_last  <= w_sel1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        GAP:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_cyc_o = w_in_grant;
  assign s_stb_o = w_in_grant;
  assign gnt_o   = r_gnt;

  // Slave-side mux is zeroed outside GRANT so the SRAM never sees stale writes.
  assign s_adr_o = w_in_grant ? (w_sel1 ? m1_adr_i : m0_adr_i) : '0;
  assign s_we_o  = w_in_grant & (w_sel1 ? m1_we_i : m0_we_i);
  assign s_sel_o = w_in_grant ? (w_sel1 ? m1_sel_i : m0_sel_i) : 4'b0000;
  assign s_dat_o = w_in_grant ? (w_sel1 ? m1_dat_i : m0_dat_i) : 32'h0;

  assign m0_ack_o = r_gnt[0] & s_ack_i;
  assign m1_ack_o = r_gnt[1] & s_ack_i;
  assign m0_err_o = r_gnt[0] & w_timeout;
  assign m1_err_o = r_gnt[1] & w_timeout;
  assign m0_dat_o = w_in_grant ? s_dat_i : 32'h0;
  assign m1_dat_o = w_in_grant ? s_dat_i : 32'h0;

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Directed and randomized bench for wb_sram_arbiter; expectations come from a
// transaction-level model (who wins, how long the grant lasts, what each master sees).
module tb_wb_sram_arbiter;

  localparam int AW      = 32;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m0_we_i = 1'b0;
  logic [AW-1:0] m0_adr_i = '0;
  logic [3:0]    m0_sel_i = '0;
  logic [31:0]   m0_dat_i = '0;
  logic [31:0]   m0_dat_o;
  logic          m0_ack_o, m0_err_o;
  logic          m1_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
  logic [AW-1:0] m1_adr_i = '0;
  logic [3:0]    m1_sel_i = '0;
  logic [31:0]   m1_dat_i = '0;
  logic [31:0]   m1_dat_o;
  logic          m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [3:0]    s_sel_o;
  logic [31:0]   s_dat_o;
  logic [31:0]   s_dat_i = '0;
  logic          s_ack_i = 1'b0;
  logic [1:0]    gnt_o;

  int checks = 0;
  int failures = 0;

  // Model state: last owner (1 = M1) and each master's current request fields.
  bit            modelLast;
  logic [AW-1:0] mAdr [2];
  bit            mWe  [2];
  logic [3:0]    mSel [2];
  logic [31:0]   mDat [2];
  logic [31:0]   slvData;

  wb_sram_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_adr_i(m0_adr_i), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_adr_i(m1_adr_i), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_adr_o(s_adr_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [AW-1:0] a, input bit w,
                               input logic [3:0] s, input logic [31:0] d);
    mAdr[idx] = a; mWe[idx] = w; mSel[idx] = s; mDat[idx] = d;
    if (idx == 0) begin
      m0_adr_i = a; m0_we_i = w; m0_sel_i = s; m0_dat_i = d;
    end else begin
      m1_adr_i = a; m1_we_i = w; m1_sel_i = s; m1_dat_i = d;
    end
  endtask

  task automatic setReq(input int idx, input bit r);
    if (idx == 0) begin m0_cyc_i = r; m0_stb_i = r; end
    else begin m1_cyc_i = r; m1_stb_i = r; end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, ".stb"}, s_stb_o, 0);
    checkOutput({tag, ".cyc"}, s_cyc_o, 0);
    checkOutput({tag, ".gnt"}, gnt_o, 0);
    checkOutput({tag, ".ack0"}, m0_ack_o, 0);
    checkOutput({tag, ".ack1"}, m1_ack_o, 0);
    checkOutput({tag, ".err0"}, m0_err_o, 0);
    checkOutput({tag, ".err1"}, m1_err_o, 0);
    checkOutput({tag, ".we"}, s_we_o, 0);
    checkOutput({tag, ".adr"}, s_adr_o, 0);
  endtask

  // One arbitration round: IDLE cycle, GRANT cycles, GAP cycle with a stray ack.
  // ackAt/abortAt are GRANT-cycle indices (-1 = never). Call when the next edge enters IDLE.
  task automatic doRound(input bit r0, input bit r1, input int ackAt, input int abortAt,
                         input string name);
    int g;
    bit ack, abort, done, expErr;
    logic [1:0] oh;
    @(posedge clk); #1;
    setReq(0, r0); setReq(1, r1);
    s_ack_i = 1'($urandom_range(0, 1));
    s_dat_i = $urandom;
    #1;
    checkIdleOutputs({name, ".idle"});
    g  = (r0 && r1) ? (modelLast ? 0 : 1) : (r1 ? 1 : 0);
    oh = (g == 1) ? 2'b10 : 2'b01;
    done = 1'b0;
    for (int k = 0; k < TIMEOUT && !done; k++) begin
      @(posedge clk); #1;
      ack   = (k == ackAt);
      abort = !ack && (k == abortAt);
      if (abort) setReq(g, 1'b0);
      s_ack_i = ack;
      s_dat_i = ack ? slvData : $urandom;
      expErr  = !ack && !abort && (k == TIMEOUT - 1);
      #1;
      checkOutput({name, ".stb"}, s_stb_o, 1);
      checkOutput({name, ".cyc"}, s_cyc_o, 1);
      checkOutput({name, ".gnt"}, gnt_o, oh);
      checkOutput({name, ".adr"}, s_adr_o, mAdr[g]);
      checkOutput({name, ".we"}, s_we_o, mWe[g]);
      checkOutput({name, ".sel"}, s_sel_o, mSel[g]);
      checkOutput({name, ".wdat"}, s_dat_o, mDat[g]);
      checkOutput({name, ".ack0"}, m0_ack_o, (g == 0) && ack);
      checkOutput({name, ".ack1"}, m1_ack_o, (g == 1) && ack);
      checkOutput({name, ".err0"}, m0_err_o, (g == 0) && expErr);
      checkOutput({name, ".err1"}, m1_err_o, (g == 1) && expErr);
      if (ack) checkOutput({name, ".rdat"}, (g == 0) ? m0_dat_o : m1_dat_o, slvData);
      done = ack || abort || (k == TIMEOUT - 1);
    end
    modelLast = (g == 1);
    @(posedge clk); #1;
    s_ack_i = 1'b1;
    s_dat_i = $urandom;
    #1;
    checkIdleOutputs({name, ".gap"});
    s_ack_i = 1'b0;
  endtask

  initial begin
    int ackAt, abortAt, r;
    // Reset state while requests are already present.
    applyStimulus(0, 32'h40, 1'b1, 4'hF, 32'h11);
    applyStimulus(1, 32'h80, 1'b1, 4'hF, 32'h22);
    setReq(0, 1'b1); setReq(1, 1'b1);
    s_ack_i = 1'b1;
    #3;
    checkIdleOutputs("reset");
    setReq(0, 1'b0); setReq(1, 1'b0);
    s_ack_i = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    modelLast = 1'b1;

    // Both masters requesting: strict alternation M0,M1,M0,M1 every 4 cycles.
    applyStimulus(0, 32'h0000_0200, 1'b0, 4'hF, 32'h0);
    applyStimulus(1, 32'h0000_0300, 1'b0, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      slvData = 32'hA000_0000 + i;
      doRound(1'b1, 1'b1, 1, -1, "rr");
    end

    // Single M0 read with a one-cycle-ack slave.
    applyStimulus(0, 32'h0000_0100, 1'b0, 4'hF, 32'h0);
    slvData = 32'hDEADBEEF;
    doRound(1'b1, 1'b0, 1, -1, "m0read");

    // M1 partial write.
    applyStimulus(1, 32'h0000_2004, 1'b1, 4'b0011, 32'h1234ABCD);
    slvData = 32'h0;
    doRound(1'b0, 1'b1, 1, -1, "m1write");

    // Timeout on M0, then the pending M1 is served.
    slvData = 32'h5555AAAA;
    doRound(1'b1, 1'b1, -1, -1, "timeout");
    doRound(1'b1, 1'b1, 0, -1, "afterto");

    // M0 aborts one cycle into GRANT; M1 wins the next tie.
    doRound(1'b1, 1'b1, -1, 1, "abort");
    doRound(1'b1, 1'b1, 1, -1, "afterab");

    // Randomized rounds.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, $urandom, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
      applyStimulus(1, $urandom, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
      slvData = $urandom;
      r = $urandom_range(1, 3);
      ackAt = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      abortAt = -1;
      if ($urandom_range(0, 3) == 0) begin
        if (ackAt < 0) abortAt = $urandom_range(0, TIMEOUT - 1);
        else if (ackAt > 0) abortAt = $urandom_range(0, ackAt - 1);
      end
      doRound(r[0], r[1], ackAt, abortAt, "rand");
    end

    // Asynchronous reset in the middle of a grant.
    @(posedge clk); #1;
    setReq(0, 1'b1); setReq(1, 1'b1);
    @(posedge clk); #1;
    checkOutput("rstmid.stb_before", s_stb_o, 1);
    s_ack_i = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("rstmid.stb", s_stb_o, 0);
    checkOutput("rstmid.cyc", s_cyc_o, 0);
    checkOutput("rstmid.gnt", gnt_o, 0);
    checkOutput("rstmid.ack0", m0_ack_o, 0);
    checkOutput("rstmid.ack1", m1_ack_o, 0);
    s_ack_i = 1'b0;
    setReq(0, 1'b0); setReq(1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    modelLast = 1'b1;
    slvData = 32'hCAFEF00D;
    doRound(1'b1, 1'b1, 1, -1, "postrst");
    doRound(1'b1, 1'b1, 0, -1, "postrst2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
